// File: rtl/lti_pkg.sv
// Shared constants, FSM state encoding and coefficient addressing for the
// time-multiplexed state-space engine.
package lti_pkg;

  localparam int unsigned NS   = 4;
  localparam int unsigned IW   = 16;
  localparam int unsigned OW   = 16;
  localparam int unsigned CW   = 16;
  localparam int unsigned SW   = 25;
  localparam int unsigned RW   = SW + CW - 1;
  localparam int unsigned CF   = 15;
  localparam int unsigned DEL  = 10;

  // One row per state plus the output row; one column per state plus the input.
  localparam int unsigned NC   = NS + 1;
  localparam int unsigned P    = NC * NC;
  localparam int unsigned L    = P + 3;
  localparam int unsigned AW   = $clog2(P);
  localparam int unsigned ACCW = RW + $clog2(NC);
  // Row counter must also hold NC, the "all products issued" marker.
  localparam int unsigned RIW  = $clog2(NC + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_UPDATE
  } state_t;

  function automatic logic [AW-1:0] coef_index(input logic [RIW-1:0] row,
                                               input logic [RIW-1:0] col);
    return AW'(32'(row) * NC + 32'(col));
  endfunction

endpackage

// File: rtl/lti_mac.sv
// Shared multiplier with registered product, followed by a wide accumulator
// that can restart on the first product of each row.
module lti_mac
  import lti_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_mul_en,
  input  logic signed [CW-1:0] i_coef,
  input  logic signed [SW-1:0] i_opnd,
  input  logic                 i_acc_en,
  input  logic                 i_acc_clr,
  output logic signed [RW-1:0] o_acc
);

  logic signed [RW-1:0]   w_ca;
  logic signed [RW-1:0]   w_ob;
  logic signed [RW-1:0]   w_prod;
  logic signed [ACCW-1:0] w_ext;
  logic signed [RW-1:0]   r_prod;
  logic signed [ACCW-1:0] r_acc;

  // Product keeps only its low RW bits, so the extreme corner wraps.
  assign w_ca   = {{(RW-CW){i_coef[CW-1]}}, i_coef};
  assign w_ob   = {{(RW-SW){i_opnd[SW-1]}}, i_opnd};
  assign w_prod = w_ca * w_ob;
  assign w_ext  = {{(ACCW-RW){r_prod[RW-1]}}, r_prod};
  assign o_acc  = r_acc[RW-1:0];

  // Register the product one cycle ahead of accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod <= '0;
    end else if (i_mul_en) begin
      r_prod <= w_prod;
    end
  end

  // Accumulate, restarting from zero on the first product of a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_acc_en) begin
      r_acc <= (i_acc_clr ? '0 : r_acc) + w_ext;
    end
  end

endmodule

// File: rtl/lti_mac_scheduler.sv
// State-space engine x' = x + (A*x + B*u)>>>DEL, y = C*x + D*u, computed with
// one shared multiplier over (NS+1)^2 cycles per sample.
module lti_mac_scheduler
  import lti_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce_in,
  input  logic signed [IW-1:0] sig_in,
  output logic signed [OW-1:0] sig_out,
  output logic                 ce_out,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  output logic                 cfg_err
);

  localparam logic [RIW-1:0] LAST_COL = RIW'(NS);
  localparam logic [RIW-1:0] LAST_ROW = RIW'(NS);
  localparam logic [RIW-1:0] ROW_END  = RIW'(NC);

  state_t                r_state;
  logic signed [CW-1:0]  r_coef  [P];
  logic signed [RW-1:0]  r_xlong [NS];
  logic signed [RW-1:0]  r_dx    [NS];
  logic signed [SW-1:0]  r_xq    [NS];
  logic signed [SW-1:0]  r_u;
  logic signed [OW-1:0]  r_y;
  logic [RIW-1:0]        r_row;
  logic [RIW-1:0]        r_col;
  // Tags travelling alongside the product (stage 1) and accumulator (stage 2).
  logic                  r_v1;
  logic                  r_first1;
  logic                  r_last1;
  logic [RIW-1:0]        r_row1;
  logic                  r_v2;
  logic                  r_last2;
  logic [RIW-1:0]        r_row2;

  logic                  w_issue;
  logic [AW-1:0]         w_cidx;
  logic signed [CW-1:0]  w_coef;
  logic signed [SW-1:0]  w_opnd;
  logic signed [RW-1:0]  w_acc;

  assign w_issue = (r_state == ST_MAC) && (r_row < ROW_END);
  assign w_cidx  = w_issue ? coef_index(r_row, r_col) : '0;
  assign w_coef  = r_coef[w_cidx];

  // Operand for the current column: a latched state value, or u in the last column.
  always_comb begin
    w_opnd = r_u;
    for (int unsigned i = 0; i < NS; i++) begin
      if (r_col == RIW'(i)) w_opnd = r_xq[i];
    end
  end

  lti_mac u_mac (
    .clk       (clk),
    .rst       (rst),
    .i_mul_en  (w_issue),
    .i_coef    (w_coef),
    .i_opnd    (w_opnd),
    .i_acc_en  (r_v1),
    .i_acc_clr (r_first1),
    .o_acc     (w_acc)
  );

  // Coefficient file: writes accepted only in IDLE with an in-range address.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < P; i++) r_coef[i] <= '0;
      cfg_err <= 1'b0;
    end else if (coef_we) begin
      if ((r_state != ST_IDLE) || ({1'b0, coef_addr} >= (AW+1)'(P))) begin
        cfg_err <= 1'b1;
      end else begin
        r_coef[coef_addr] <= coef_data;
      end
    end
  end

  // Sequencer: accept sample, issue row-major products, collect rows, update state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_row    <= '0;
      r_col    <= '0;
      r_v1     <= 1'b0;
      r_first1 <= 1'b0;
      r_last1  <= 1'b0;
      r_row1   <= '0;
      r_v2     <= 1'b0;
      r_last2  <= 1'b0;
      r_row2   <= '0;
      r_u      <= '0;
      r_y      <= '0;
      sig_out  <= '0;
      ce_out   <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      for (int unsigned i = 0; i < NS; i++) begin
        r_xlong[i] <= '0;
        r_dx[i]    <= '0;
        r_xq[i]    <= '0;
      end
    end else begin
      ce_out   <= 1'b0;
      r_v1     <= w_issue;
      r_first1 <= (r_col == '0);
      r_last1  <= (r_col == LAST_COL);
      r_row1   <= r_row;
      r_v2     <= r_v1;
      r_last2  <= r_last1;
      r_row2   <= r_row1;
      if (ce_in && (r_state != ST_IDLE)) overrun <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (ce_in) begin
            r_u <= {{(SW-IW){sig_in[IW-1]}}, sig_in};
            for (int unsigned i = 0; i < NS; i++) begin
              r_xq[i] <= r_xlong[i][SW+CF-1:CF];
            end
            r_row   <= '0;
            r_col   <= '0;
            busy    <= 1'b1;
            r_state <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (w_issue) begin
            if (r_col == LAST_COL) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
          // A row is complete once its last product has been accumulated.
          if (r_v2 && r_last2) begin
            if (r_row2 == LAST_ROW) begin
              r_y     <= w_acc[OW+CF-1:CF];
              r_state <= ST_UPDATE;
            end else begin
              for (int unsigned i = 0; i < NS; i++) begin
                if (r_row2 == RIW'(i)) r_dx[i] <= w_acc;
              end
            end
          end
        end
        ST_UPDATE: begin
          for (int unsigned i = 0; i < NS; i++) begin
            r_xlong[i] <= r_xlong[i] + (r_dx[i] >>> DEL);
          end
          sig_out <= r_y;
          ce_out  <= 1'b1;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lti_mac_scheduler.sv
// Scoreboard bench for lti_mac_scheduler: expected outputs are computed by a
// bench-side state-space model at each accepted sample and checked at ce_out.
module tb_lti_mac_scheduler;
  import lti_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ce_in;
  logic signed [IW-1:0] sig_in;
  logic signed [OW-1:0] sig_out;
  logic                 ce_out;
  logic                 busy;
  logic                 overrun;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 cfg_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [15:0] y;
    time                t;
  } exp_t;
  exp_t q[$];

  logic signed [15:0] m_coef [25];
  logic signed [39:0] m_xl   [4];

  always #5 clk = ~clk;

  lti_mac_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .ce_in     (ce_in),
    .sig_in    (sig_in),
    .sig_out   (sig_out),
    .ce_out    (ce_out),
    .busy      (busy),
    .overrun   (overrun),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .cfg_err   (cfg_err)
  );

  // One sample of the state-space system, returning y and advancing m_xl.
  function automatic logic signed [15:0] model_step(input logic signed [15:0] u);
    logic signed [24:0] opnd [5];
    logic signed [63:0] s;
    logic signed [39:0] dx [4];
    logic signed [15:0] y;
    longint a, b;
    y = '0;
    for (int i = 0; i < 4; i++) opnd[i] = m_xl[i][39:15];
    opnd[4] = u;
    for (int r = 0; r < 5; r++) begin
      s = 0;
      for (int c = 0; c < 5; c++) begin
        a = m_coef[r*5+c];
        b = opnd[c];
        s = s + a * b;
      end
      if (r < 4) dx[r] = s[39:0];
      else       y     = s[30:15];
    end
    for (int i = 0; i < 4; i++) m_xl[i] = m_xl[i] + (dx[i] >>> 10);
    return y;
  endfunction

  // Scoreboard monitor: every ce_out must match the oldest expectation, value and latency.
  always @(negedge clk) begin
    if (rst === 1'b0 && ce_out === 1'b1) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ce_out sig_out=%0d required=no ce_out", sig_out);
      end else begin
        e = q.pop_front();
        if (sig_out !== e.y) begin
          errors++;
          $display("FAIL sb_sig_out got=%0d exp=%0d", sig_out, e.y);
        end
        checks++;
        if (($time - e.t) !== time'(10*L + 5)) begin
          errors++;
          $display("FAIL sb_latency got=%0t exp=%0t", $time - e.t, time'(10*L + 5));
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; ce_in = 1'b0; coef_we = 1'b0; sig_in = '0; coef_addr = '0; coef_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 25; i++) m_coef[i] = '0;
    for (int i = 0; i < 4; i++) m_xl[i] = '0;
    q.delete();
  endtask

  task automatic write_coef(input int addr, input logic signed [15:0] d, input bit ok);
    coef_we = 1'b1; coef_addr = AW'(addr); coef_data = d;
    @(posedge clk);
    #1 coef_we = 1'b0;
    if (ok) m_coef[addr] = d;
  endtask

  task automatic pulse(input logic signed [15:0] u, input bit accept);
    exp_t e;
    ce_in = 1'b1; sig_in = u;
    @(posedge clk);
    if (accept) begin
      e.y = model_step(u);
      e.t = $time;
      q.push_back(e);
    end
    #1 ce_in = 1'b0;
  endtask

  // Pulse at the minimum period; returns #1 after the ce_out edge.
  task automatic sample_periodic(input logic signed [15:0] u);
    pulse(u, 1'b1);
    repeat (L) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout_ce_out pending=%0d required=0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (sig_out !== '0)   begin errors++; $display("FAIL rst_sig_out got=%0d exp=0", sig_out); end
    checks++; if (ce_out  !== 1'b0) begin errors++; $display("FAIL rst_ce_out got=%b exp=0", ce_out); end
    checks++; if (busy    !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_cfg_err got=%b exp=0", cfg_err); end
  endtask

  task automatic test_gain();
    do_reset();
    write_coef(24, 16'sd16384, 1'b1);
    pulse(16'sd1000, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gain_busy got=%b exp=1", busy); end
    wait_idle();
    checks++; if (sig_out !== 16'sd500) begin errors++; $display("FAIL gain_value got=%0d exp=500", sig_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gain_busy_done got=%b exp=0", busy); end
  endtask

  task automatic test_integrator();
    do_reset();
    write_coef(4, 16'sd16384, 1'b1);
    write_coef(20, 16'sd16384, 1'b1);
    for (int k = 1; k <= 17; k++) begin
      sample_periodic(16'sd1024);
      if (k == 9) begin
        checks++; if (sig_out !== 16'sd2) begin errors++; $display("FAIL integ_s9 got=%0d exp=2", sig_out); end
      end
      if (k == 17) begin
        checks++; if (sig_out !== 16'sd4) begin errors++; $display("FAIL integ_s17 got=%0d exp=4", sig_out); end
      end
    end
    wait_idle();
  endtask

  task automatic test_overrun();
    do_reset();
    write_coef(24, 16'sd16384, 1'b1);
    pulse(16'sd1000, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    pulse(-16'sd5, 1'b0);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got=%b exp=1", overrun); end
    wait_idle();
    checks++; if (sig_out !== 16'sd500) begin errors++; $display("FAIL overrun_value got=%0d exp=500", sig_out); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_config();
    exp_t e;
    do_reset();
    write_coef(24, 16'sd16384, 1'b1);
    pulse(16'sd1000, 1'b1);
    write_coef(24, 16'sd100, 1'b0);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_busy_err got=%b exp=1", cfg_err); end
    wait_idle();
    pulse(16'sd1000, 1'b1);
    wait_idle();
    // Write and sample strobe in the same IDLE cycle: the new D must be used.
    ce_in = 1'b1; sig_in = 16'sd1000;
    coef_we = 1'b1; coef_addr = AW'(24); coef_data = 16'sd8192;
    @(posedge clk);
    m_coef[24] = 16'sd8192;
    e.y = model_step(16'sd1000);
    e.t = $time;
    q.push_back(e);
    #1 ce_in = 1'b0; coef_we = 1'b0;
    wait_idle();
    checks++; if (sig_out !== 16'sd250) begin errors++; $display("FAIL cfg_same_cycle got=%0d exp=250", sig_out); end
    do_reset();
    write_coef(25, 16'sd1, 1'b0);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_addr_err got=%b exp=1", cfg_err); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    write_coef(24, 16'sd16384, 1'b1);
    pulse(16'sd1000, 1'b1);
    wait_idle();
    pulse(16'sd1000, 1'b1);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (sig_out !== '0) begin errors++; $display("FAIL midrst_sig_out got=%0d exp=0", sig_out); end
    rst = 1'b0;
    for (int i = 0; i < 25; i++) m_coef[i] = '0;
    for (int i = 0; i < 4; i++) m_xl[i] = '0;
    repeat (35) @(posedge clk);
    #1;
    write_coef(24, 16'sd16384, 1'b1);
    pulse(16'sd1000, 1'b1);
    wait_idle();
    checks++; if (sig_out !== 16'sd500) begin errors++; $display("FAIL midrst_rerun got=%0d exp=500", sig_out); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        if (r < 4 && c < 4) write_coef(r*5+c, 16'($signed(int'($urandom_range(4096)) - 2048)), 1'b1);
        else                write_coef(r*5+c, 16'($urandom), 1'b1);
      end
    end
    for (int k = 0; k < 100; k++) sample_periodic(16'($urandom));
    wait_idle();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout time=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_gain();
    test_integrator();
    test_overrun();
    test_config();
    test_reset_midrun();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
